// File: rtl/bp_me_io_cmd_arbiter_pkg.sv
// Shared types and helpers for the host-side I/O command arbiter.
//
// Contents:
//   bp_cce_mem_msg_s         command/response message carried on every port
//   cce_mem_msg_width_lp     packed width of bp_cce_mem_msg_s
//   src_id_width(n)          width of a source index for n sources (clog2, min 1)
//   `BP_IO_ARB_SRC_ID_WIDTH  macro form of src_id_width for legacy callers
package bp_me_io_cmd_arbiter_pkg;

    typedef struct packed {
        logic [3:0]  msg_type;
        logic [39:0] addr;
        logic [63:0] data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    // A single source still needs a 1-bit tag so the tag FIFO has nonzero width.
    function automatic int src_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`ifndef BP_IO_ARB_SRC_ID_WIDTH
`define BP_IO_ARB_SRC_ID_WIDTH(n) bp_me_io_cmd_arbiter_pkg::src_id_width(n)
`endif

// File: rtl/bp_me_io_cmd_arbiter_tag_fifo.sv
// Tag FIFO for the I/O command arbiter: remembers which source issued each
// in-flight command so in-order responses can be steered back.
//
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset (empties the FIFO)
//   data_i, push_i   tag to enqueue; ignored when full
//   pop_i            dequeue head; ignored when empty
//   data_o           current head (valid when empty_o=0)
//   full_o, empty_o  occupancy flags
//
// No bypass: a push while full is dropped even if a pop happens the same cycle.
// Pointers wrap at depth_p, so non-power-of-two depths work.
module bp_me_io_cmd_arbiter_tag_fifo #(
    parameter int width_p = 1,
    parameter int depth_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               push_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int ptr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int cnt_w_lp = $clog2(depth_p + 1);

    logic [width_p-1:0]  mem_reg [depth_p];
    logic [ptr_w_lp-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [cnt_w_lp-1:0] count_reg;
    logic                push_ok, pop_ok;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(depth_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign full_o  = (count_reg == cnt_w_lp'(depth_p));
    assign empty_o = (count_reg == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + cnt_w_lp'(1);
                2'b01:   count_reg <= count_reg - cnt_w_lp'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= data_i;
    end

    // Head is read combinationally: responses are steered in the same cycle.
    assign data_o = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/bp_me_io_cmd_arbiter.sv
// Merges num_src_p host-side I/O command sources onto one memory command port
// and routes each in-order response back to the source that issued it.
//
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   src_cmd_i/_v_i      per-source commands (packed, source i at slice i)
//   src_cmd_yumi_o      one-hot (or 0) consume strobe back to sources
//   src_resp_o          response message, broadcast to all sources
//   src_resp_v_o        one-hot response valid for the owning source
//   src_resp_ready_i    per-source response ready
//   mem_cmd_o/_v_o      granted command toward the host link
//   mem_cmd_ready_i     host link ready
//   mem_resp_i/_v_i     response from the host link
//   mem_resp_yumi_o     response consumed (or dropped when no tag is pending)
//   err_o               sticky: a response arrived with no outstanding tag
//
// Build option: define BP_IO_ARB_FIXED_PRIO_EN for fixed priority (lowest
// valid index wins, no rotation pointer). Default is round-robin.
module bp_me_io_cmd_arbiter
    import bp_me_io_cmd_arbiter_pkg::*;
#(
    parameter int num_src_p         = 2,
    parameter int max_outstanding_p = 4,
    parameter int msg_width_p       = cce_mem_msg_width_lp
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_src_p*msg_width_p-1:0] src_cmd_i,
    input  logic [num_src_p-1:0]           src_cmd_v_i,
    output logic [num_src_p-1:0]           src_cmd_yumi_o,
    output logic [msg_width_p-1:0]         src_resp_o,
    output logic [num_src_p-1:0]           src_resp_v_o,
    input  logic [num_src_p-1:0]           src_resp_ready_i,
    output logic [msg_width_p-1:0]         mem_cmd_o,
    output logic                           mem_cmd_v_o,
    input  logic                           mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]         mem_resp_i,
    input  logic                           mem_resp_v_i,
    output logic                           mem_resp_yumi_o,
    output logic                           err_o
);

    localparam int src_id_width_lp = src_id_width(num_src_p);
    typedef logic [src_id_width_lp-1:0] src_id_t;

    src_id_t grant_idx;
    src_id_t tag_head;
    logic    tag_full, tag_empty;
    logic    issue, resp_pop;
    logic    err_reg;

`ifdef BP_IO_ARB_FIXED_PRIO_EN
    // Scan high to low so the lowest valid index is the last (winning) write.
    always_comb begin
        grant_idx = '0;
        for (int i = num_src_p - 1; i >= 0; i--) begin
            if (src_cmd_v_i[i]) grant_idx = src_id_t'(i);
        end
    end
`else
    src_id_t rr_ptr_reg, rr_ptr_next;
    logic    found;
    int      cand;

    // First valid source at or after the pointer, wrapping past num_src_p-1.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < num_src_p; i++) begin
            cand = int'(rr_ptr_reg) + i;
            if (cand >= num_src_p) cand = cand - num_src_p;
            if (!found && src_cmd_v_i[src_id_t'(cand)]) begin
                grant_idx = src_id_t'(cand);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (issue) begin
            rr_ptr_next = (grant_idx == src_id_t'(num_src_p - 1))
                        ? '0 : grant_idx + src_id_t'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) rr_ptr_reg <= '0;
        else         rr_ptr_reg <= rr_ptr_next;
    end
`endif

    // Outputs are gated by reset so they drop asynchronously mid-cycle.
    assign mem_cmd_v_o = (|src_cmd_v_i) & ~tag_full & ~reset_i;
    assign issue       = mem_cmd_v_o & mem_cmd_ready_i;
    assign mem_cmd_o   = reset_i ? '0
                       : src_cmd_i[int'(grant_idx)*msg_width_p +: msg_width_p];

    // With no tag pending the response is swallowed so the link never stalls.
    assign mem_resp_yumi_o = mem_resp_v_i & ~reset_i
                           & (tag_empty | src_resp_ready_i[tag_head]);
    assign resp_pop        = mem_resp_yumi_o & ~tag_empty;
    assign src_resp_o      = reset_i ? '0 : mem_resp_i;

    for (genvar gi = 0; gi < num_src_p; gi++) begin : g_src
        assign src_cmd_yumi_o[gi] = issue & (grant_idx == src_id_t'(gi));
        assign src_resp_v_o[gi]   = mem_resp_v_i & ~tag_empty & ~reset_i
                                  & (tag_head == src_id_t'(gi));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                         err_reg <= 1'b0;
        else if (mem_resp_v_i && tag_empty)  err_reg <= 1'b1;
    end
    assign err_o = err_reg;

    bp_me_io_cmd_arbiter_tag_fifo #(
        .width_p (src_id_width_lp),
        .depth_p (max_outstanding_p)
    ) tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (grant_idx),
        .push_i  (issue),
        .pop_i   (resp_pop),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Scoreboard bench for bp_me_io_cmd_arbiter: the stimulus process computes the
// expected command/response outcome from a queue-based reference model and
// pushes it; a negedge monitor pops and compares whenever the DUT presents.
module tb_bp_me_io_cmd_arbiter;
    import bp_me_io_cmd_arbiter_pkg::*;

    localparam int N     = 2;
    localparam int DEPTH = 4;
    localparam int W     = cce_mem_msg_width_lp;

    typedef bp_cce_mem_msg_s msg_t;
    typedef struct packed { logic v; logic [N-1:0] yumi; msg_t msg; } cmd_exp_t;
    typedef struct packed { logic [N-1:0] v; logic yumi; msg_t msg; } resp_exp_t;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic [N*W-1:0] src_cmd_i;
    logic [N-1:0]   src_cmd_v_i = '0;
    logic [N-1:0]   src_cmd_yumi_o;
    logic [W-1:0]   src_resp_o;
    logic [N-1:0]   src_resp_v_o;
    logic [N-1:0]   src_resp_ready_i = '0;
    logic [W-1:0]   mem_cmd_o;
    logic           mem_cmd_v_o;
    logic           mem_cmd_ready_i = 1'b0;
    logic [W-1:0]   mem_resp_i = '0;
    logic           mem_resp_v_i = 1'b0;
    logic           mem_resp_yumi_o;
    logic           err_o;

    msg_t src_msg [N];
    msg_t resp_msg;

    always #5 clk = ~clk;

    always_comb begin
        src_cmd_i = '0;
        for (int i = 0; i < N; i++) src_cmd_i[i*W +: W] = src_msg[i];
    end

    bp_me_io_cmd_arbiter #(
        .num_src_p         (N),
        .max_outstanding_p (DEPTH),
        .msg_width_p       (W)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .src_cmd_i        (src_cmd_i),
        .src_cmd_v_i      (src_cmd_v_i),
        .src_cmd_yumi_o   (src_cmd_yumi_o),
        .src_resp_o       (src_resp_o),
        .src_resp_v_o     (src_resp_v_o),
        .src_resp_ready_i (src_resp_ready_i),
        .mem_cmd_o        (mem_cmd_o),
        .mem_cmd_v_o      (mem_cmd_v_o),
        .mem_cmd_ready_i  (mem_cmd_ready_i),
        .mem_resp_i       (mem_resp_i),
        .mem_resp_v_i     (mem_resp_v_i),
        .mem_resp_yumi_o  (mem_resp_yumi_o),
        .err_o            (err_o)
    );

    // ---------------- scoreboard state and reference model ----------------
    cmd_exp_t  cmd_q  [$];
    resp_exp_t resp_q [$];
    int        inflight [$];   // source id of each outstanding command, oldest first
    int        rr = 0;         // next source to be favoured
    bit        m_err = 1'b0;   // model error flag after this cycle's edge
    bit        exp_err = 1'b0; // error flag visible during the current cycle
    bit        mon_en = 1'b0;
    int        n_vec = 0;
    int        n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
`ifdef BP_IO_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (v[k]) return k;
`else
        for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
`endif
        return 0;
    endfunction

    function automatic msg_t rand_msg();
        msg_t m;
        m.msg_type = 4'($urandom());
        m.addr     = 40'({$urandom(), $urandom()});
        m.data     = {$urandom(), $urandom()};
        return m;
    endfunction

    task automatic rand_msgs();
        for (int i = 0; i < N; i++) src_msg[i] = rand_msg();
        resp_msg = rand_msg();
    endtask

    // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic cycle(input logic [N-1:0] v, input logic rdy,
                         input logic rv, input logic [N-1:0] rrdy);
        cmd_exp_t  ce;
        resp_exp_t re;
        int        occ, g;
        bit        do_pop;
        exp_err          = m_err;
        src_cmd_v_i      = v;
        mem_cmd_ready_i  = rdy;
        mem_resp_v_i     = rv;
        mem_resp_i       = resp_msg;
        src_resp_ready_i = rrdy;
        occ    = inflight.size();
        do_pop = 1'b0;
        if (rv) begin
            re.msg = resp_msg;
            re.v   = '0;
            if (occ == 0) begin
                re.yumi = 1'b1;
                m_err   = 1'b1;
            end else begin
                re.v[inflight[0]] = 1'b1;
                re.yumi           = rrdy[inflight[0]];
                do_pop            = rrdy[inflight[0]];
            end
            resp_q.push_back(re);
        end
        if (v != '0) begin
            g       = pick(v);
            ce.v    = (occ < DEPTH);
            ce.yumi = '0;
            ce.msg  = src_msg[g];
            if (ce.v && rdy) begin
                ce.yumi[g] = 1'b1;
                inflight.push_back(g);
                rr = (g + 1) % N;
            end
            cmd_q.push_back(ce);
        end
        if (do_pop) void'(inflight.pop_front());
        @(posedge clk);
        #1;
    endtask

    // Reset asserted mid-cycle with both sources and a response valid.
    task automatic mid_cycle_reset();
        mon_en           = 1'b0;
        rand_msgs();
        src_cmd_v_i      = '1;
        mem_cmd_ready_i  = 1'b1;
        mem_resp_v_i     = 1'b1;
        mem_resp_i       = resp_msg;
        src_resp_ready_i = '1;
        #2 reset_i = 1'b1;
        #1;
        check("rst_cmd_v",     mem_cmd_v_o,     0);
        check("rst_cmd_yumi",  src_cmd_yumi_o,  0);
        check("rst_cmd_msg",   mem_cmd_o,       0);
        check("rst_resp_v",    src_resp_v_o,    0);
        check("rst_resp_msg",  src_resp_o,      0);
        check("rst_resp_yumi", mem_resp_yumi_o, 0);
        check("rst_err",       err_o,           0);
        $display("reset applied mid-cycle at t=%0t", $time);
        @(posedge clk);
        #1;
        reset_i          = 1'b0;
        src_cmd_v_i      = '0;
        mem_resp_v_i     = 1'b0;
        inflight.delete();
        rr      = 0;
        m_err   = 1'b0;
        exp_err = 1'b0;
        mon_en  = 1'b1;
    endtask

    // ---------------- monitor ----------------
    cmd_exp_t  mon_c;
    resp_exp_t mon_r;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_cmd_v_o || src_cmd_yumi_o != '0 || cmd_q.size() > 0) begin
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", {mem_cmd_v_o, src_cmd_yumi_o}, 0);
                end else begin
                    mon_c = cmd_q.pop_front();
                    check("cmd_v", mem_cmd_v_o, mon_c.v);
                    check("cmd_yumi", src_cmd_yumi_o, mon_c.yumi);
                    if (mon_c.v) check("cmd_msg", mem_cmd_o, mon_c.msg);
                    $display("cmd  t=%0t v=%0b yumi=%b addr=%h", $time, mem_cmd_v_o,
                             src_cmd_yumi_o, mem_cmd_o[103:64]);
                end
            end
            if (src_resp_v_o != '0 || mem_resp_yumi_o || resp_q.size() > 0) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", {src_resp_v_o, mem_resp_yumi_o}, 0);
                end else begin
                    mon_r = resp_q.pop_front();
                    check("resp_v", src_resp_v_o, mon_r.v);
                    check("resp_yumi", mem_resp_yumi_o, mon_r.yumi);
                    if (mon_r.v != '0) check("resp_msg", src_resp_o, mon_r.msg);
                    $display("resp t=%0t v=%b yumi=%0b data=%h", $time, src_resp_v_o,
                             mem_resp_yumi_o, src_resp_o[63:0]);
                end
            end
            check("err", err_o, exp_err);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        rand_msgs();
        #2;
        check("init_cmd_v", mem_cmd_v_o, 0);
        check("init_err",   err_o,       0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        mon_en  = 1'b1;

        // Alternating grants, then the tag FIFO fills and valid drops.
        for (int i = 0; i < 5; i++) begin
            rand_msgs();
            cycle(2'b11, 1'b1, 1'b0, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            rand_msgs();
            cycle(2'b00, 1'b0, 1'b1, 2'b11);
        end

        // Ordered routing: src0 @0x100 then src1 @0x200.
        rand_msgs();
        src_msg[0].addr = 40'h100;
        cycle(2'b01, 1'b1, 1'b0, 2'b00);
        rand_msgs();
        src_msg[1].addr = 40'h200;
        cycle(2'b10, 1'b1, 1'b0, 2'b00);
        rand_msgs();
        cycle(2'b00, 1'b0, 1'b1, 2'b11);
        rand_msgs();
        cycle(2'b00, 1'b0, 1'b1, 2'b11);

        // Response backpressure from src0 for 3 cycles, held message stable.
        rand_msgs();
        cycle(2'b01, 1'b1, 1'b0, 2'b00);
        rand_msgs();
        for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 1'b1, 2'b10);
        cycle(2'b00, 1'b0, 1'b1, 2'b11);

        // Spurious response with nothing outstanding; error must stick.
        rand_msgs();
        cycle(2'b00, 1'b0, 1'b1, 2'b11);
        for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 1'b0, 2'b00);

        // Randomized traffic; responses only while commands are outstanding.
        for (int i = 0; i < 400; i++) begin
            rand_msgs();
            cycle(N'($urandom()), ($urandom_range(3) != 0),
                  (inflight.size() > 0) && ($urandom_range(1) == 1),
                  N'($urandom()));
        end

        // Drain before reset so no late responses remain.
        guard = 0;
        while (inflight.size() > 0 && guard < 50) begin
            rand_msgs();
            cycle(2'b00, 1'b0, 1'b1, 2'b11);
            guard++;
        end
        check("drain_timeout", guard < 50, 1);

        mid_cycle_reset();

        // Pointer restarts at 0 after reset.
        for (int i = 0; i < 3; i++) begin
            rand_msgs();
            cycle(2'b11, 1'b1, 1'b0, 2'b00);
        end
        for (int i = 0; i < 3; i++) begin
            rand_msgs();
            cycle(2'b00, 1'b0, 1'b1, 2'b11);
        end
        cycle(2'b00, 1'b0, 1'b0, 2'b00);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
